pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It generates per-stage enable (hold) and flush (bubble) controls from the following conditions:
- load-use hazards seen in ID/EX;
- taken branches/jumps resolved in EX;
- multi-cycle data-memory handshakes in MEM;
- halt instructions (ecall/ebreak) decoded in ID.

It runs a RUN/DRAIN/HALTED state machine and keeps cycle, stall, flush and retire performance counters.

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: per-stage enables/flushes,
// RUN/DRAIN/HALTED sequencing after ecall/ebreak, and performance counters.
module pipe_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_halt,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  wb_valid,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  halted,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      instret_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  state_t               state_r, state_next_s;
  logic [DRAIN_W-1:0]   drain_r, drain_next_s;
  logic                 mem_stall_s, load_use_s, flush_evt_s, stall_evt_s;

  assign mem_stall_s = mem_req & ~mem_ready;
  assign load_use_s  = ex_mem_read & (ex_rd_addr != REG_ZERO) &
                       ((id_use_rs1 & (id_rs1_addr == ex_rd_addr)) |
                        (id_use_rs2 & (id_rs2_addr == ex_rd_addr)));

  // Stage controls and next state, priority mem_stall > branch > load-use > halt
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    halted       = 1'b0;
    flush_evt_s  = 1'b0;
    stall_evt_s  = 1'b0;
    state_next_s = state_r;
    drain_next_s = drain_r;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            stall_evt_s = 1'b1;
          end else if (ex_branch_taken) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_evt_s = 1'b1;
          end else if (load_use_s) begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            idex_flush  = 1'b1;
            stall_evt_s = 1'b1;
          end else if (id_halt) begin
            {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
            ifid_flush   = 1'b1;
            stall_evt_s  = 1'b1;
            state_next_s = ST_DRAIN;
            drain_next_s = DRAIN_INIT;
          end else begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          end
        end
        ST_DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (mem_stall_s) begin
            drain_next_s = drain_r;
          end else begin
            {idex_en, exmem_en, memwb_en} = 3'b111;
            if (drain_r == DRAIN_ZERO) begin
              state_next_s = ST_HALTED;
            end else begin
              drain_next_s = drain_r - DRAIN_ONE;
            end
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          state_next_s = ST_RUN;
          drain_next_s = DRAIN_ZERO;
        end
      endcase
    end
  end

  // State, drain counter and performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      drain_r     <= DRAIN_ZERO;
      cycle_cnt   <= {CNT_W{1'b0}};
      stall_cnt   <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
      instret_cnt <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      drain_r   <= drain_next_s;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_evt_s) stall_cnt <= stall_cnt + CNT_W'(1);
      else             stall_cnt <= stall_cnt;
      if (flush_evt_s) flush_cnt <= flush_cnt + CNT_W'(1);
      else             flush_cnt <= flush_cnt;
      if (wb_valid & memwb_en) instret_cnt <= instret_cnt + CNT_W'(1);
      else                     instret_cnt <= instret_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random stimulus checked
// against a rule-level reference model; counters use an 8-bit width to exercise wrap.
module tb_pipe_ctrl;
  localparam int AW = 5;
  localparam int DC = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_use_rs1, id_use_rs2, id_halt, ex_mem_read, ex_branch_taken;
  logic mem_req, mem_ready, wb_valid;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
  logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt, instret_cnt;
  logic [6:0] ctl;
  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

  pipe_ctrl #(.REG_ADDR_W(AW), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_halt(id_halt),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .wb_valid(wb_valid),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .instret_cnt(instret_cnt)
  );

  typedef struct packed {
    logic rst;
    logic [AW-1:0] rs1, rs2;
    logic u1, u2, halt;
    logic [AW-1:0] exrd;
    logic mr, br, mreq, mrdy, wbv;
  } stim_t;

  typedef struct packed {
    logic [6:0] ctl;
    logic halted;
    logic cv;
    logic [CW-1:0] cyc, stl, fl, ir;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0=running, 1=draining, 2=halted
  int m_mode = 0;
  int m_drained = 0;
  bit m_known = 1'b0;
  int m_cyc = 0, m_stl = 0, m_fl = 0, m_ir = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    bit ms, lu;
    logic [6:0] c;
    bit h;
    ms = s.mreq && !s.mrdy;
    lu = s.mr && (s.exrd != 0) && ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
    h = 1'b0;
    // ctl bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_en
    if (s.rst)                c = 7'b0010100;
    else if (m_mode == 2) begin c = 7'b0000000; h = 1'b1; end
    else if (m_mode == 1)     c = ms ? 7'b0010100 : 7'b0011111;
    else if (ms)              c = 7'b0000000;
    else if (s.br)            c = 7'b1111111;
    else if (lu)              c = 7'b0001111;
    else if (s.halt)          c = 7'b0111011;
    else                      c = 7'b1101011;
    e.ctl = c; e.halted = h; e.cv = m_known;
    e.cyc = CW'(m_cyc); e.stl = CW'(m_stl); e.fl = CW'(m_fl); e.ir = CW'(m_ir);
    if (s.rst) begin
      m_mode = 0; m_drained = 0; m_known = 1'b1;
      m_cyc = 0; m_stl = 0; m_fl = 0; m_ir = 0;
    end else begin
      m_cyc = (m_cyc + 1) % 256;
      if (m_mode == 0 && !c[6]) m_stl = (m_stl + 1) % 256;
      if (m_mode == 0 && !ms && s.br) m_fl = (m_fl + 1) % 256;
      if (s.wbv && c[0]) m_ir = (m_ir + 1) % 256;
      if (m_mode == 0) begin
        if (!ms && !s.br && !lu && s.halt) begin m_mode = 1; m_drained = 0; end
      end else if (m_mode == 1) begin
        if (!ms) begin
          m_drained++;
          if (m_drained == DC) m_mode = 2;
        end
      end
    end
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    @(negedge clk);
    reset = s.rst; id_rs1_addr = s.rs1; id_rs2_addr = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; id_halt = s.halt;
    ex_rd_addr = s.exrd; ex_mem_read = s.mr; ex_branch_taken = s.br;
    mem_req = s.mreq; mem_ready = s.mrdy; wb_valid = s.wbv;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    cycle(s);
    cycle(s);
  endtask

  function automatic stim_t rand_stim(input bit allow_halt);
    stim_t s;
    s.rst  = 1'b0;
    s.rs1  = AW'($urandom_range(0, 3));
    s.rs2  = AW'($urandom_range(0, 3));
    s.u1   = ($urandom_range(0, 1) == 0);
    s.u2   = ($urandom_range(0, 1) == 0);
    s.halt = allow_halt && ($urandom_range(0, 24) == 0);
    s.exrd = AW'($urandom_range(0, 3));
    s.mr   = ($urandom_range(0, 2) == 0);
    s.br   = ($urandom_range(0, 5) == 0);
    s.mreq = ($urandom_range(0, 2) == 0);
    s.mrdy = ($urandom_range(0, 1) == 0);
    s.wbv  = ($urandom_range(0, 1) == 0);
    return s;
  endfunction

  // Monitor: compares DUT outputs with the oldest queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctl", int'(ctl), int'(e.ctl));
        chk("halted", int'(halted), int'(e.halted));
        if (e.cv) begin
          chk("cycle_cnt", int'(cycle_cnt), int'(e.cyc));
          chk("stall_cnt", int'(stall_cnt), int'(e.stl));
          chk("flush_cnt", int'(flush_cnt), int'(e.fl));
          chk("instret_cnt", int'(instret_cnt), int'(e.ir));
        end
      end
    end
  end

  initial begin
    stim_t s;
    int halt_wait;
    reset = 1'b1; id_rs1_addr = '0; id_rs2_addr = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_halt = 1'b0; ex_rd_addr = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; wb_valid = 1'b0;

    // Reset state
    do_reset();
    #3 chk("reset_ctl", int'(ctl), 7'b0010100);

    // Load-use on x5
    do_reset();
    s = idle(); s.mr = 1'b1; s.exrd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    cycle(s);
    #3 chk("t1_pc_en", int'(pc_en), 0);
    chk("t1_idex_flush", int'(idex_flush), 1);
    cycle(idle());
    #3 chk("t1_pc_en_after", int'(pc_en), 1);
    chk("t1_stall_cnt", int'(stall_cnt), 1);

    // Load to x0 is no hazard
    do_reset();
    s = idle(); s.mr = 1'b1; s.exrd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
    cycle(s);
    #3 chk("t2_pc_en", int'(pc_en), 1);
    cycle(idle());
    #3 chk("t2_stall_cnt", int'(stall_cnt), 0);

    // Branch beats load-use
    do_reset();
    s = idle(); s.mr = 1'b1; s.exrd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1; s.br = 1'b1;
    cycle(s);
    #3 chk("t3_ctl", int'(ctl), 7'b1111111);
    cycle(idle());
    #3 chk("t3_flush_cnt", int'(flush_cnt), 1);
    chk("t3_stall_cnt", int'(stall_cnt), 0);

    // Memory stall holding a taken branch
    do_reset();
    s = idle(); s.mreq = 1'b1; s.br = 1'b1;
    repeat (4) begin
      cycle(s);
      #3 chk("t4_freeze", int'(ctl), 0);
    end
    s.mrdy = 1'b1;
    cycle(s);
    #3 chk("t4_flush_ctl", int'(ctl), 7'b1111111);
    cycle(idle());
    #3 chk("t4_flush_cnt", int'(flush_cnt), 1);

    // Halt with one frozen drain cycle
    do_reset();
    s = idle(); s.halt = 1'b1;
    cycle(s);
    cycle(idle());
    s = idle(); s.mreq = 1'b1;
    cycle(s);
    cycle(idle());
    cycle(idle());
    #3 chk("t5_not_yet_halted", int'(halted), 0);
    cycle(idle());
    #3 chk("t5_halted", int'(halted), 1);
    chk("t5_ctl", int'(ctl), 0);

    // Reset out of HALTED
    repeat (14) cycle(rand_stim(1'b1));
    #3 chk("t6_still_halted", int'(halted), 1);
    s = idle(); s.rst = 1'b1;
    cycle(s);
    cycle(idle());
    #3 chk("t6_halted", int'(halted), 0);
    chk("t6_cycle_cnt", int'(cycle_cnt), 0);
    chk("t6_instret_cnt", int'(instret_cnt), 0);
    chk("t6_pc_en", int'(pc_en), 1);

    // Counter wrap: 300 cycles without reset or halt
    do_reset();
    repeat (300) cycle(rand_stim(1'b0));
    #3 chk("wrap_cycle_cnt", int'(cycle_cnt), 43);

    // Random traffic with halts and resets
    do_reset();
    halt_wait = 0;
    repeat (1500) begin
      s = rand_stim(1'b1);
      if (m_mode == 2) begin
        halt_wait++;
        if (halt_wait > 5) begin s.rst = 1'b1; halt_wait = 0; end
      end else if ($urandom_range(0, 199) == 0) begin
        s.rst = 1'b1;
      end
      cycle(s);
    end

    repeat (3) @(negedge clk);
    #4;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
